// File: rtl/gc_poll_engine.sv
// GameCube controller poll engine: sends the 24-bit poll command on the
// open-drain data line, then captures the controller's 64-bit reply.
module gc_poll_engine #(
  parameter int unsigned CLKS_PER_US = 10,
  parameter int unsigned SAMPLE_US   = 2,
  parameter int unsigned TIMEOUT_US  = 200
) (
  input  logic        SYSCLK,
  input  logic        SYSRESET,
  input  logic        start,
  input  logic        rumble,
  input  logic        data_in,
  output logic        data_oe,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [63:0] buttons
);

  localparam int unsigned TO_CYC = TIMEOUT_US * CLKS_PER_US;
  localparam int unsigned CW     = $clog2(TO_CYC + 1);

  // Counter reload values; bit-cell phases are loaded as (length - 1).
  localparam logic [CW-1:0] ONE_U_M1   = CW'(CLKS_PER_US - 1);
  localparam logic [CW-1:0] THREE_U_M1 = CW'(3 * CLKS_PER_US - 1);
  localparam logic [CW-1:0] SAMPLE_LD  = CW'(SAMPLE_US * CLKS_PER_US);
  localparam logic [CW-1:0] TO_LAST    = CW'(TO_CYC - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_TX_LOW    = 4'd1;
  localparam logic [3:0] S_TX_HIGH   = 4'd2;
  localparam logic [3:0] S_TX_STOP   = 4'd3;
  localparam logic [3:0] S_RX_FALL   = 4'd4;
  localparam logic [3:0] S_RX_SAMPLE = 4'd5;
  localparam logic [3:0] S_RX_RISE   = 4'd6;
  localparam logic [3:0] S_RXS_FALL  = 4'd7;
  localparam logic [3:0] S_RXS_RISE  = 4'd8;
  localparam logic [3:0] S_ABORT     = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    bit_cnt_q, bit_cnt_d;
  logic [23:0]   tx_q, tx_d;
  logic [63:0]   rx_q, rx_d;
  logic [63:0]   buttons_q, buttons_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [2:0]    sync_q;
  logic          lvl_c;
  logic          fall_c;

  function automatic logic [CW-1:0] low_len(input logic b);
    return b ? ONE_U_M1 : THREE_U_M1;
  endfunction

  function automatic logic [CW-1:0] high_len(input logic b);
    return b ? THREE_U_M1 : ONE_U_M1;
  endfunction

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // Resets to the idle (pulled-up) level so no false edge follows reset.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) sync_q <= 3'b111;
    else          sync_q <= {sync_q[1:0], data_in};
  end

  assign lvl_c  = sync_q[1];
  assign fall_c = sync_q[2] & ~sync_q[1];

  // State and datapath registers.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      buttons_q <= '0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      buttons_q <= buttons_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and output logic for the poll transaction.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    buttons_d = buttons_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_d      = {8'h40, 8'h03, 7'd0, rumble};
          bit_cnt_d = '0;
          cnt_d     = low_len(1'b0);
          busy_d    = 1'b1;
          state_d   = S_TX_LOW;
        end
      end
      S_TX_LOW: begin
        if (cnt_q == '0) begin
          cnt_d   = high_len(tx_q[23]);
          state_d = S_TX_HIGH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_TX_HIGH: begin
        if (cnt_q == '0) begin
          if (bit_cnt_q == 7'd23) begin
            bit_cnt_d = '0;
            cnt_d     = ONE_U_M1;
            state_d   = S_TX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
            tx_d      = {tx_q[22:0], 1'b0};
            cnt_d     = low_len(tx_q[22]);
            state_d   = S_TX_LOW;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_TX_STOP: begin
        if (cnt_q == '0) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = S_RX_FALL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RX_FALL, S_RXS_FALL: begin
        if (fall_c) begin
          if (state_q == S_RX_FALL) begin
            cnt_d   = SAMPLE_LD;
            state_d = S_RX_SAMPLE;
          end else begin
            cnt_d   = '0;
            state_d = S_RXS_RISE;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RX_SAMPLE: begin
        if (cnt_q == '0) begin
          rx_d      = {rx_q[62:0], lvl_c};
          bit_cnt_d = bit_cnt_q + 7'd1;
          state_d   = S_RX_RISE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RX_RISE: begin
        if (lvl_c) begin
          cnt_d   = '0;
          state_d = (bit_cnt_q >= 7'd64) ? S_RXS_FALL : S_RX_FALL;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RXS_RISE: begin
        if (lvl_c) begin
          buttons_d = rx_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Entering ABORT: flag the failure and free the engine in the same cycle.
    if (state_d == S_ABORT && state_q != S_ABORT) begin
      timeout_d = 1'b1;
      busy_d    = 1'b0;
    end

    // Only the host-driven low phases pull the pad.
    data_oe_d = (state_d == S_TX_LOW) || (state_d == S_TX_STOP);
  end

  assign data_oe = data_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign buttons = buttons_q;

endmodule

// File: tb/tb_gc_poll_engine.sv
// Self-checking bench for gc_poll_engine with a controller model on the pad.
module tb_gc_poll_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rumble = 1'b0;
  logic        ctrl_low = 1'b0;
  logic        data_in;
  logic        data_oe;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [63:0] buttons;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: k counts cycles since start acceptance.
  logic        m_busy = 1'b0;
  int          k = 0;
  logic [23:0] m_cmd = '0;
  logic [63:0] m_btn = '0;
  logic [63:0] m_reply = '0;
  logic        ev_is_done = 1'b0;
  int          ev_lo = 0;
  int          ev_hi = 0;
  int          ev_cnt = 0;
  int          n_done = 0;
  logic        e_oe;
  logic        ev_seen;
  logic        ev_other;
  logic        wave [0:1023];
  int          lo_run [0:31];
  int          hi_run [0:31];
  int          npulse;
  int          tx_total;

  // Open-drain pad with external pull-up.
  assign data_in = (data_oe | ctrl_low) ? 1'b0 : 1'b1;

  gc_poll_engine dut (
    .SYSCLK  (clk),
    .SYSRESET(rst),
    .start   (start),
    .rumble  (rumble),
    .data_in (data_in),
    .data_oe (data_oe),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .buttons (buttons)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t k=%0d: got %h, want %h", name, $time, k, act, exp);
    end
  endtask

  // Expected pad drive k cycles into a transaction: 4us cells, '1' = 1us low,
  // '0' = 3us low, then a 1us stop pulse.
  function automatic logic oe_at(input int kk, input logic [23:0] cmd);
    logic b;
    int   ph;
    if (kk >= 960) return (kk < 970);
    b  = cmd[23 - kk / 40];
    ph = kk % 40;
    return (ph < (b ? 10 : 30));
  endfunction

  // Transaction tracker.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      k      <= 0;
    end else if (start && !m_busy) begin
      m_busy <= 1'b1;
      k      <= 0;
      m_cmd  <= {16'h4003, 7'd0, rumble};
    end else begin
      k <= k + 1;
      if (m_busy && k >= ev_hi) m_busy <= 1'b0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      m_btn = '0;
    end else begin
      e_oe = (m_busy && k < 970) ? oe_at(k, m_cmd) : 1'b0;
      chk("data_oe", 64'(data_oe), 64'(e_oe));
      if (m_busy && k < 1024) wave[k] = data_oe;
      if (m_busy && k == 0) ev_cnt = 0;
      if (done) n_done++;
      if (!m_busy) begin
        chk("idle busy", 64'(busy), 64'd0);
        chk("idle done", 64'(done), 64'd0);
        chk("idle timeout", 64'(timeout), 64'd0);
      end else if (k < ev_lo) begin
        chk("busy", 64'(busy), 64'd1);
        chk("early done", 64'(done), 64'd0);
        chk("early timeout", 64'(timeout), 64'd0);
      end else begin
        ev_seen  = ev_is_done ? done : timeout;
        ev_other = ev_is_done ? timeout : done;
        chk("wrong end pulse", 64'(ev_other), 64'd0);
        if (ev_seen) begin
          ev_cnt++;
          if (ev_is_done) m_btn = m_reply;
          chk("busy at end pulse", 64'(busy), 64'd0);
        end
        if (k == ev_hi) chk("end pulse count", 64'(ev_cnt), 64'd1);
      end
      chk("buttons", buttons, m_btn);
    end
  end

  task automatic start_txn(input logic r, input logic is_done, input int lo, input int hi,
                           input logic [63:0] reply);
    ev_is_done = is_done;
    ev_lo      = lo;
    ev_hi      = hi;
    m_reply    = reply;
    rumble     = r;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_k(input int target);
    int n = 0;
    while (k < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("transaction ends", 64'(m_busy), 64'd0);
    repeat (5) @(negedge clk);
  endtask

  // Controller reply: nbits data cells from k=990, optional stop bit, or
  // hold the line low afterwards.
  task automatic drive_reply(input logic [63:0] w, input int nbits, input logic hold_low);
    logic b;
    wait_k(990);
    for (int i = 0; i < nbits; i++) begin
      b = w[63 - i];
      ctrl_low = 1'b1;
      repeat (b ? 10 : 30) @(negedge clk);
      ctrl_low = 1'b0;
      repeat (b ? 30 : 10) @(negedge clk);
    end
    ctrl_low = 1'b1;
    if (!hold_low) begin
      repeat (10) @(negedge clk);
      ctrl_low = 1'b0;
    end
  endtask

  // Split the captured TX waveform into low-pulse / released-gap lengths.
  task automatic analyze();
    int i = 0;
    int s;
    npulse   = 0;
    tx_total = 0;
    while (i < 1024) begin
      if (wave[i]) begin
        s = i;
        while (i < 1024 && wave[i]) i++;
        if (npulse < 32) lo_run[npulse] = i - s;
        tx_total = i;
        s = i;
        while (i < 1024 && !wave[i]) i++;
        if (npulse < 32) hi_run[npulse] = i - s;
        npulse++;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset data_oe", 64'(data_oe), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset timeout", 64'(timeout), 64'd0);
    chk("reset buttons", buttons, 64'd0);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // No reply: timeout exactly 2000 cycles after the stop bit ends.
    start_txn(1'b0, 1'b0, 2970, 2970, 64'd0);
    wait_idle();
    analyze();
    chk("A pulse count", 64'(npulse), 64'd25);
    chk("A bit23 low", 64'(lo_run[0]), 64'd30);
    chk("A bit23 high", 64'(hi_run[0]), 64'd10);
    chk("A bit22 low", 64'(lo_run[1]), 64'd10);
    chk("A bit22 high", 64'(hi_run[1]), 64'd30);
    chk("A bit0 low", 64'(lo_run[23]), 64'd30);
    chk("A stop low", 64'(lo_run[24]), 64'd10);
    chk("A tx total", 64'(tx_total), 64'd970);
    chk("A buttons", buttons, 64'd0);

    // Full reply with rumble=1; a start pulsed mid-transaction is ignored.
    start_txn(1'b1, 1'b1, 3561, 3567, 64'h0080808080800000);
    fork
      drive_reply(64'h0080808080800000, 64, 1'b0);
      begin
        wait_k(500);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
      end
    join
    wait_idle();
    analyze();
    chk("B bit1 low", 64'(lo_run[22]), 64'd30);
    chk("B rumble low", 64'(lo_run[23]), 64'd10);
    chk("B rumble high", 64'(hi_run[23]), 64'd30);
    chk("B tx total", 64'(tx_total), 64'd970);
    chk("B buttons", buttons, 64'h0080808080800000);
    chk("B done count", 64'(n_done), 64'd1);

    // No reply again: previous buttons retained.
    start_txn(1'b0, 1'b0, 2970, 2970, 64'd0);
    wait_idle();
    chk("C buttons kept", buttons, 64'h0080808080800000);

    // Reply cut after 30 bits, line stuck low.
    start_txn(1'b0, 1'b0, 4190, 4260, 64'd0);
    drive_reply(64'hA5C3_0F96_5A3C_F069, 30, 1'b1);
    wait_idle();
    ctrl_low = 1'b0;
    repeat (5) @(negedge clk);
    chk("D buttons kept", buttons, 64'h0080808080800000);
    chk("D done count", 64'(n_done), 64'd1);

    // Asynchronous reset while driving low.
    start_txn(1'b0, 1'b0, 2970, 2970, 64'd0);
    wait_k(100);
    chk("E oe before reset", 64'(data_oe), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("E oe async reset", 64'(data_oe), 64'd0);
    chk("E busy async reset", 64'(busy), 64'd0);
    chk("E buttons reset", buttons, 64'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean full transaction after reset.
    start_txn(1'b0, 1'b1, 3561, 3567, 64'hFEDC_BA98_7654_3210);
    drive_reply(64'hFEDC_BA98_7654_3210, 64, 1'b0);
    wait_idle();
    chk("F buttons", buttons, 64'hFEDC_BA98_7654_3210);
    chk("F done count", 64'(n_done), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
